spi_slave: RTL and testbench
============================

# spi_slave

Mode-0 SPI slave endpoint that sits on the far side of the SPI master's wires: it consumes `sclk`, `mosi` and `cs`, and drives `miso`. All pins are oversampled in the system clock domain. It deserialises MSB-first bytes into a ready/valid receive port, and serialises a preloaded transmit byte back to the master. It is the bench-side and loopback counterpart for the SPI master in full-duplex transfers.

## Interface
- `DATA_W`, 8, bits per SPI word
- `SYNC_STAGES`, 2, synchroniser flops on `sclk_i`/`mosi_i`/`cs_i` (≥2)

Ports:
- `clk_i` in 1: system clock; the only clock in the block
- `aresetn_i` in 1: asynchronous, active-low reset
- `sclk_i` in 1: SPI clock from master, idle low (mode 0)
- `mosi_i` in 1: serial data from master
- `cs_i` in 1: chip select, active low
- `miso_o` out 1: serial data to master
- `tx_data_i` in DATA_W: byte to return to master
- `tx_load_i` in 1: writes `tx_data_i` into the TX holding register
- `rx_data_o` out DATA_W: last received byte
- `rx_valid_o` out 1: `rx_data_o` holds an unconsumed byte
- `rx_ready_i` in 1: consumer accepts `rx_data_o`
- `rx_overrun_o` out 1: sticky overrun flag (see Configuration)

## Operation
- Synchronisation:
  - `sclk_i`, `mosi_i` and `cs_i` each pass through a `SYNC_STAGES`-deep synchroniser, followed by one history flop.
  - Edges are detected from the synchroniser output and the history flop:
    - `sclk_rise`, `sclk_fall`
    - `cs_fall`, `cs_rise`
- FSM states:
  - IDLE (cs high):
    - `miso_o`=0.
    - On `cs_fall`: load the TX shift register from the holding register, set `bit_cnt`=0, go to SHIFT.
  - SHIFT:
    - `miso_o` = TX shift register MSB.
    - On `sclk_rise`: shift synced `mosi` into the RX shift register, `bit_cnt`++.
    - On `sclk_fall`: shift the TX register left by one, filling the low bit with 0.
    - On `cs_rise`: go to IDLE from any bit count. A partial byte is discarded, `bit_cnt` clears, and no `rx_valid_o` is generated.
- Word completion:
  - The `sclk_rise` with `bit_cnt`=DATA_W-1 writes `{rx_shift[DATA_W-2:0], mosi}` into `rx_data_o`, sets `rx_valid_o`, and wraps `bit_cnt` to 0.
  - The next `sclk_fall` reloads the TX shift register from the holding register instead of shifting.
  - While cs stays low, consecutive words stream without gaps.
- TX holding register:
  - `tx_load_i` updates it on any cycle. The value persists and is reused until reloaded.
  - If `tx_load_i` coincides with the cycle that loads the TX shift register (`cs_fall` or word-boundary `sclk_fall`), the new `tx_data_i` is used directly.
- RX handshake:
  - `rx_valid_o` clears on a cycle with `rx_valid_o && rx_ready_i`.
  - If completion and acceptance happen in the same cycle, `rx_valid_o` stays 1 with the new data.
  - `rx_data_o` is stable while `rx_valid_o`=1, except on overrun.
- Reset (asynchronous, any time, including mid-frame) forces:
  - FSM=IDLE, all shift registers and counters 0, synchroniser flops 0, with `cs` synchroniser flops set to 1 (inactive)
  - TX holding register 0
  - `miso_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `rx_overrun_o`=0

## Timing
- Sampling latency:
  - An edge present on a pin before clk_i edge k is acted on at clk_i edge k+SYNC_STAGES.
  - `rx_valid_o` is visible after edge k+SYNC_STAGES for the last bit's `sclk` rise.
- `miso_o` delay:
  - After a `cs_i` fall, `miso_o` shows the MSB after SYNC_STAGES+1 clk_i edges.
  - After each `sclk_i` fall, `miso_o` changes after SYNC_STAGES+1 clk_i edges.
- SCLK limits: `sclk_i` high and low phases must each last ≥ SYNC_STAGES+2 clk_i periods. Faster SCLK is unsupported.
- CS setup: `cs_i` low must precede the first `sclk_i` rise by ≥ SYNC_STAGES+2 clk_i periods.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - A word completion while `rx_valid_o`=1 and `rx_ready_i`=0 overwrites `rx_data_o` with the new byte and sets `rx_overrun_o`.
  - `rx_overrun_o` stays set until reset.
- `SPI_SLAVE_OVERRUN_EN` undefined:
  - Same overwrite behaviour.
  - `rx_overrun_o` is tied to 0 and no flag logic is present.

## Test plan
- Reset check: reset asserted → `miso_o`=0, `rx_valid_o`=0, `rx_data_o`=0x00, `rx_overrun_o`=0.
- Single byte, full duplex:
  - Stimulus: `tx_load_i` with 0xA5, cs low, master shifts out 0x3C at clk_i/16, `rx_ready_i`=1.
  - Response: `rx_data_o`=0x3C with a one-cycle `rx_valid_o`; master receives 0xA5 on `miso_o`.
- Back-to-back words:
  - Stimulus: cs held low over 3 bytes 0x01, 0x80, 0xFF; `tx_load_i` with 0x11, 0x22, 0x33, each loaded before its word boundary.
  - Response: three `rx_valid_o` events with matching data; master receives 0x11, 0x22, 0x33.
- Aborted frame: cs rises after 5 bits of 0xF0 → no `rx_valid_o`; the next full frame of 0x5A is received correctly as 0x5A.
- Overrun:
  - Stimulus: `rx_ready_i`=0, two bytes 0xAA then 0x55.
  - Response: `rx_data_o`=0x55, `rx_valid_o`=1. With `SPI_SLAVE_OVERRUN_EN`, `rx_overrun_o`=1; without it, `rx_overrun_o`=0.
- Reset mid-frame: `aresetn_i` pulsed low after 4 bits → all outputs return to reset values immediately; the following 0xC3 frame is received intact.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave endpoint, oversampled in the clk_i domain.
// Deserialises MSB-first words onto a ready/valid receive port and
// serialises a preloaded transmit word back on miso_o.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN (sticky rx_overrun_o flag).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | cs inactive, miso_o held 0, waiting for cs fall
// SHIFT  | cs active, sampling mosi on sclk rise, shifting tx on sclk fall
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  input  logic              cs_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_hist_q, cs_hist_q;

  logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [DATA_W-1:0] tx_src;
  logic              word_last;

  // Pin synchronisers plus one history flop for edge detection; cs resets inactive.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;

  // A load coinciding with a shift-register reload bypasses the holding register.
  assign tx_src    = tx_load_i ? tx_data_i : tx_hold_q;
  assign word_last = (bit_cnt_q == CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next-state: cs alone frames a transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output: miso only driven from the tx shifter while selected.
  always_comb begin
    miso_o = 1'b0;
    if (state_q == ST_SHIFT) miso_o = tx_shift_q[DATA_W-1];
  end

  // Datapath next-state: shifters, bit counter, receive handshake.
  always_comb begin
    tx_hold_d  = tx_src;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    bit_cnt_d  = bit_cnt_q;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          tx_shift_d = tx_src;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          // Partial words are dropped without raising rx_valid.
          tx_shift_d = '0;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (word_last) begin
              rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // bit_cnt is 0 on a fall only right after a word completed.
          if (sclk_fall) begin
            if (bit_cnt_q == '0) tx_shift_d = tx_src;
            else                 tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      tx_hold_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      tx_hold_q  <= tx_hold_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q;
  logic overrun_set;

  assign overrun_set = (state_q == ST_SHIFT) && !cs_rise && sclk_rise && word_last &&
                       rx_valid_q && !rx_ready_i;

  // Sticky overrun: a completed word landed on an unconsumed one.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i)       overrun_q <= 1'b0;
    else if (overrun_set) overrun_q <= 1'b1;
  end

  assign rx_overrun_o = overrun_q;
`else
  assign rx_overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: directed test-plan frames followed by random frames,
// checked against a word-level model of what the master sent and loaded.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       sclk, mosi, cs;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;

  int checks = 0;
  int failures = 0;

  logic [7:0] mo_w[5];
  logic [7:0] tx_w[5];
  logic [7:0] mi_w[5];
  logic [7:0] model_hold;
  logic       do_load;
  logic       exp_ovr;

  logic [7:0] cap_q[$];
  int         vcyc = 0;
  int         base, vbase;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .aresetn_i   (aresetn),
    .sclk_i      (sclk),
    .mosi_i      (mosi),
    .cs_i        (cs),
    .miso_o      (miso),
    .tx_data_i   (tx_data),
    .tx_load_i   (tx_load),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .rx_overrun_o(rx_overrun)
  );

  always #5 clk = ~clk;

  // Receive-side monitor: count valid cycles and record accepted words.
  always @(negedge clk) begin
    if (rx_valid) begin
      vcyc++;
      if (rx_ready) cap_q.push_back(rx_data);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    model_hold = v;
    cyc(1);
    tx_load = 1'b0;
  endtask

  // One SCLK period at clk/16; master samples miso just before its rising edge.
  task automatic shift_bit(input logic b, output logic m, input logic ld, input logic [7:0] ldv);
    mosi = b;
    if (ld) begin
      cyc(5);
      pulse_load(ldv);
      cyc(2);
    end else begin
      cyc(8);
    end
    m = miso;
    sclk = 1'b1;
    cyc(8);
    sclk = 1'b0;
  endtask

  // nw full words, then an optional partial word of tail bits, then cs rises.
  task automatic run_frame(input int nw, input int tail);
    int   nwt;
    logic m;
    nwt = nw + ((tail > 0) ? 1 : 0);
    if (do_load) pulse_load(tx_w[0]);
    base  = cap_q.size();
    vbase = vcyc;
    cs = 1'b0;
    cyc(8);
    for (int w = 0; w < nwt; w++) begin
      int nb;
      nb = (w < nw) ? 8 : tail;
      mi_w[w] = 8'h00;
      for (int i = 0; i < nb; i++) begin
        shift_bit(mo_w[w][7-i], m, do_load && (i == 0) && (w + 1 < nw), tx_w[w+1]);
        mi_w[w] = {mi_w[w][6:0], m};
      end
    end
    cyc(8);
    cs = 1'b1;
    cyc(8);
  endtask

  task automatic verify_frame(input string tag, input int nw);
    check({tag, "_rxcount"}, cap_q.size() - base, nw);
    check({tag, "_validcyc"}, vcyc - vbase, nw);
    for (int w = 0; w < nw; w++) begin
      if (cap_q.size() > base + w)
        check($sformatf("%s_rx%0d", tag, w), cap_q[base+w], mo_w[w]);
      check($sformatf("%s_miso%0d", tag, w), mi_w[w], do_load ? tx_w[w] : model_hold);
    end
  endtask

  initial begin
    logic m;
    aresetn = 1'b0;
    sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
    tx_data = 8'h00; tx_load = 1'b0; rx_ready = 1'b1;
    model_hold = 8'h00; do_load = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif

    cyc(3);
    check("reset_miso", miso, 0);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 8'h00);
    check("reset_overrun", rx_overrun, 0);
    aresetn = 1'b1;
    cyc(4);

    // Single byte, full duplex.
    mo_w[0] = 8'h3C; tx_w[0] = 8'hA5;
    run_frame(1, 0);
    verify_frame("single", 1);

    // Back-to-back words with a fresh tx word each boundary.
    mo_w[0] = 8'h01; mo_w[1] = 8'h80; mo_w[2] = 8'hFF;
    tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
    run_frame(3, 0);
    verify_frame("b2b", 3);

    // Aborted frame: 5 bits of 0xF0, then a clean 0x5A frame.
    mo_w[0] = 8'hF0; tx_w[0] = 8'h99;
    run_frame(0, 5);
    check("abort_rxcount", cap_q.size() - base, 0);
    check("abort_validcyc", vcyc - vbase, 0);
    mo_w[0] = 8'h5A; tx_w[0] = 8'h6B;
    run_frame(1, 0);
    verify_frame("after_abort", 1);

    // Overrun: consumer stalled across two completed words.
    rx_ready = 1'b0;
    mo_w[0] = 8'hAA; mo_w[1] = 8'h55;
    tx_w[0] = 8'h0F; tx_w[1] = 8'hF0;
    run_frame(2, 0);
    check("ovr_data", rx_data, 8'h55);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", rx_overrun, exp_ovr);
    check("ovr_miso0", mi_w[0], 8'h0F);
    check("ovr_miso1", mi_w[1], 8'hF0);
    base = cap_q.size();
    rx_ready = 1'b1;
    cyc(1);
    check("ovr_accept_clears_valid", rx_valid, 0);
    check("ovr_accept_data", cap_q.size() > base ? cap_q[base] : 8'hXX, 8'h55);
    check("ovr_flag_sticky", rx_overrun, exp_ovr);

    // Reset mid-frame after 4 bits; holding register returns to 0.
    pulse_load(8'hFF);
    cs = 1'b0;
    cyc(8);
    for (int i = 0; i < 4; i++) shift_bit(1'b1, m, 1'b0, 8'h00);
    cyc(4);
    check("midrst_pre_miso", miso, 1);
    aresetn = 1'b0;
    #1;
    check("midrst_miso", miso, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_overrun", rx_overrun, 0);
    cs = 1'b1; sclk = 1'b0;
    cyc(3);
    aresetn = 1'b1;
    model_hold = 8'h00;
    cyc(8);
    do_load = 1'b0;
    mo_w[0] = 8'hC3;
    run_frame(1, 0);
    verify_frame("after_midrst", 1);

    // Held tx word reused across a frame without a new load.
    pulse_load(8'h7E);
    mo_w[0] = 8'h24; mo_w[1] = 8'hDB;
    run_frame(2, 0);
    verify_frame("hold_reuse", 2);
    do_load = 1'b1;

    // Random frames of 1..3 words, occasionally followed by an aborted frame.
    for (int r = 0; r < 6; r++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        mo_w[w] = 8'($urandom);
        tx_w[w] = 8'($urandom);
      end
      run_frame(nw, 0);
      verify_frame($sformatf("rand%0d", r), nw);
      if ($urandom_range(0, 1) == 1) begin
        mo_w[0] = 8'($urandom);
        tx_w[0] = 8'($urandom);
        run_frame(0, $urandom_range(1, 7));
        check($sformatf("rand%0d_abort_rxcount", r), cap_q.size() - base, 0);
      end
    end
    check("final_overrun", rx_overrun, 0);
    check("final_idle_miso", miso, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
